// File: rtl/pyr_mul_pkg.sv
// Shared constants, width helpers and the saturation function for pyr_mul_acc_pipe.
package pyr_mul_pkg;

  localparam int MAX_W     = 64;
  localparam int MAX_W_LOG = 6;

  localparam int DEF_A_WIDTH   = 17;
  localparam int DEF_B_WIDTH   = 17;
  localparam int DEF_A_SIGNED  = 1;
  localparam int DEF_B_SIGNED  = 0;
  localparam int DEF_NUM_STAGE = 4;
  localparam int DEF_ACC_WIDTH = 48;
  localparam int DEF_SHIFT     = 0;
  localparam int DEF_OUT_WIDTH = 34;

  typedef struct packed {
    logic signed [MAX_W-1:0] value;
    logic                    clipped;
  } sat_t;

  // An extended operand of this width holds any signed/unsigned product exactly.
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic logic signed [MAX_W-1:0] ext_operand(input logic [MAX_W-1:0] v,
                                                          input int width,
                                                          input logic is_signed);
    logic [MAX_W-1:0] mask;
    mask = (width >= MAX_W) ? {MAX_W{1'b1}} : ((64'd1 << width) - 64'd1);
    if (is_signed && v[MAX_W_LOG'(width - 1)]) begin
      return v | ~mask;
    end else begin
      return v & mask;
    end
  endfunction

  function automatic sat_t sat_signed(input logic signed [MAX_W-1:0] value, input int width);
    sat_t r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      r.value   = hi;
      r.clipped = 1'b1;
    end else if (value < lo) begin
      r.value   = lo;
      r.clipped = 1'b1;
    end else begin
      r.value   = value;
      r.clipped = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pyr_mul_acc_pipe_if.sv
// Sample/result bundle between the gradient datapath, pyr_mul_acc_pipe and the flow solver.
interface pyr_mul_acc_pipe_if
  import pyr_mul_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) ();
  logic                 ce;
  logic                 in_valid;
  logic [A_WIDTH-1:0]   din0;
  logic [B_WIDTH-1:0]   din1;
  logic                 first;
  logic                 last;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] dout;
  logic                 overflow;

  modport master (output ce, in_valid, din0, din1, first, last,
                  input  out_valid, dout, overflow);
  modport slave  (input  ce, in_valid, din0, din1, first, last,
                  output out_valid, dout, overflow);
endinterface

// File: rtl/pyr_mul_core.sv
// Signedness-aware pipelined multiplier: NUM_STAGE-1 register stages, the owner's
// output register completes the NUM_STAGE latency. Valid/first/last travel alongside.
module pyr_mul_core
  import pyr_mul_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int A_SIGNED  = DEF_A_SIGNED,
  parameter int B_SIGNED  = DEF_B_SIGNED,
  parameter int NUM_STAGE = DEF_NUM_STAGE
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ce,
  input  logic                              in_valid,
  input  logic [A_WIDTH-1:0]                din0,
  input  logic [B_WIDTH-1:0]                din1,
  input  logic                              first,
  input  logic                              last,
  output logic                              out_valid,
  output logic                              out_first,
  output logic                              out_last,
  output logic signed [A_WIDTH+B_WIDTH:0]   prod
);
  localparam int PW    = prod_width(A_WIDTH, B_WIDTH);
  localparam int DEPTH = NUM_STAGE - 1;

  logic signed [PW-1:0] a_ext_s, b_ext_s, a_r, b_r, mult_s;
  logic [DEPTH-1:0]     valid_r, first_r, last_r;

  assign a_ext_s = PW'(ext_operand(MAX_W'(din0), A_WIDTH, A_SIGNED != 0));
  assign b_ext_s = PW'(ext_operand(MAX_W'(din1), B_WIDTH, B_SIGNED != 0));
  assign mult_s  = a_r * b_r;

  // Valid shift register, the only core state cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= '0;
    end else if (ce) begin
      valid_r[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid_r[i] <= valid_r[i-1];
    end
  end

  // Operand registers and sideband shift registers.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_r        <= a_ext_s;
      b_r        <= b_ext_s;
      first_r[0] <= first;
      last_r[0]  <= last;
      for (int i = 1; i < DEPTH; i++) begin
        first_r[i] <= first_r[i-1];
        last_r[i]  <= last_r[i-1];
      end
    end
  end

  if (DEPTH == 1) begin : g_comb
    assign prod = mult_s;
  end else begin : g_reg
    logic signed [PW-1:0] prod_r [DEPTH-1];
    // Product pipeline behind the multiplier, retimed into the DSP by synthesis.
    always_ff @(posedge clk) begin
      if (ce) begin
        prod_r[0] <= mult_s;
        for (int i = 1; i < DEPTH - 1; i++) prod_r[i] <= prod_r[i-1];
      end
    end
    assign prod = prod_r[DEPTH-2];
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_first = first_r[DEPTH-1];
  assign out_last  = last_r[DEPTH-1];
endmodule

// File: rtl/pyr_mul_acc_pipe.sv
// Pipelined multiply(-accumulate) with rounding shift and saturation.
// Define PYR_MUL_ACC_EN to build the first/last-framed accumulator stage.
module pyr_mul_acc_pipe
  import pyr_mul_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int A_SIGNED  = DEF_A_SIGNED,
  parameter int B_SIGNED  = DEF_B_SIGNED,
  parameter int NUM_STAGE = DEF_NUM_STAGE,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input logic              clk,
  input logic              reset,
  pyr_mul_acc_pipe_if.slave bus
);
  localparam int PW = prod_width(A_WIDTH, B_WIDTH);
  localparam logic signed [MAX_W-1:0] RND =
    (SHIFT > 0) ? (64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : 64'sd0;

  logic                    core_valid_s, core_first_s, core_last_s;
  logic signed [PW-1:0]    core_prod_s;
  logic                    res_valid_s;
  logic signed [MAX_W-1:0] res_s, shifted_s;
  sat_t                    sat_s;
  logic                    out_valid_r, overflow_r;
  logic [OUT_WIDTH-1:0]    dout_r;

  pyr_mul_core #(
    .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .A_SIGNED(A_SIGNED),
    .B_SIGNED(B_SIGNED), .NUM_STAGE(NUM_STAGE)
  ) u_core (
    .clk(clk), .reset(reset), .ce(bus.ce), .in_valid(bus.in_valid),
    .din0(bus.din0), .din1(bus.din1), .first(bus.first), .last(bus.last),
    .out_valid(core_valid_s), .out_first(core_first_s), .out_last(core_last_s),
    .prod(core_prod_s)
  );

`ifdef PYR_MUL_ACC_EN
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic                        emit_r;

  // Group accumulator: first restarts (dropping any partial sum), last emits.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r  <= '0;
      emit_r <= 1'b0;
    end else if (bus.ce) begin
      emit_r <= core_valid_s & core_last_s;
      if (core_valid_s) begin
        acc_r <= core_first_s ? ACC_WIDTH'(core_prod_s) : acc_r + ACC_WIDTH'(core_prod_s);
      end
    end
  end

  assign res_valid_s = emit_r;
  assign res_s       = MAX_W'(acc_r);
`else
  localparam int unused_acc_width = ACC_WIDTH;
  logic unused_side_s;
  assign unused_side_s = core_first_s ^ core_last_s;
  assign res_valid_s   = core_valid_s;
  assign res_s         = MAX_W'(core_prod_s);
`endif

  // Round half up, then clip to the signed output range.
  always_comb begin
    shifted_s = (res_s + RND) >>> SHIFT;
    sat_s     = sat_signed(shifted_s, OUT_WIDTH);
  end

  // Output register; dout/overflow only move when a result is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      dout_r      <= '0;
      overflow_r  <= 1'b0;
    end else if (bus.ce) begin
      out_valid_r <= res_valid_s;
      if (res_valid_s) begin
        dout_r     <= sat_s.value[OUT_WIDTH-1:0];
        overflow_r <= sat_s.clipped;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.dout      = dout_r;
  assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_pyr_mul_acc_pipe.sv
// Self-checking bench for pyr_mul_acc_pipe (default and SHIFT=2/OUT_WIDTH=16 instances).
module tb_pyr_mul_acc_pipe;
  localparam int NS = 4;
`ifdef PYR_MUL_ACC_EN
  localparam int LAT = NS + 1;
`else
  localparam int LAT = NS;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pyr_mul_acc_pipe_if #(.A_WIDTH(17), .B_WIDTH(17), .OUT_WIDTH(34)) bus1 ();
  pyr_mul_acc_pipe_if #(.A_WIDTH(17), .B_WIDTH(17), .OUT_WIDTH(16)) bus2 ();

  assign bus2.ce       = bus1.ce;
  assign bus2.in_valid = bus1.in_valid;
  assign bus2.din0     = bus1.din0;
  assign bus2.din1     = bus1.din1;
  assign bus2.first    = bus1.first;
  assign bus2.last     = bus1.last;

  pyr_mul_acc_pipe #(
    .A_WIDTH(17), .B_WIDTH(17), .A_SIGNED(1), .B_SIGNED(0), .NUM_STAGE(NS),
    .ACC_WIDTH(48), .SHIFT(0), .OUT_WIDTH(34)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  pyr_mul_acc_pipe #(
    .A_WIDTH(17), .B_WIDTH(17), .A_SIGNED(1), .B_SIGNED(0), .NUM_STAGE(NS),
    .ACC_WIDTH(48), .SHIFT(2), .OUT_WIDTH(16)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  typedef struct {
    longint raw;
    int     due;
  } exp_t;

  exp_t   exp_q[$];
  int     n_assert = 0;
  int     n_fail   = 0;
  int     ce_count = 0;
  int     consumed = 0;
  longint acc_m    = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void round_sat(input longint raw, input int sh, input int w,
                                    output longint v, output longint o);
    longint r, hi, lo;
    if (sh > 0) r = (raw + (longint'(1) << (sh - 1))) >>> sh;
    else        r = raw;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    o = 0;
    v = r;
    if (r > hi) begin v = hi; o = 1; end
    if (r < lo) begin v = lo; o = 1; end
  endfunction

  task automatic accept(input logic [16:0] a, input logic [16:0] b, input bit f, input bit l);
    longint p;
    p = longint'($signed(a)) * longint'(b);
`ifdef PYR_MUL_ACC_EN
    acc_m = f ? p : acc_m + p;
    acc_m = (acc_m <<< 16) >>> 16;
    if (l) exp_q.push_back('{acc_m, ce_count + LAT - 1});
`else
    exp_q.push_back('{p + longint'(f & l & 1'b0), ce_count + LAT - 1});
`endif
  endtask

  task automatic check_outputs();
    longint v, o;
    bit     due;
    while (exp_q.size() > 0 && exp_q[0].due < ce_count) void'(exp_q.pop_front());
    due = (exp_q.size() > 0) && (exp_q[0].due == ce_count);
    check("out_valid1", 64'(bus1.out_valid), 64'(due));
    check("out_valid2", 64'(bus2.out_valid), 64'(due));
    if (due) begin
      round_sat(exp_q[0].raw, 0, 34, v, o);
      check("dout1", 64'($signed(bus1.dout)), v);
      check("overflow1", 64'(bus1.overflow), o);
      round_sat(exp_q[0].raw, 2, 16, v, o);
      check("dout2", 64'($signed(bus2.dout)), v);
      check("overflow2", 64'(bus2.overflow), o);
    end
  endtask

  task automatic step(input bit c, input bit v, input logic [16:0] a, input logic [16:0] b,
                      input bit f, input bit l, input bit r);
    bus1.ce = c; bus1.in_valid = v; bus1.din0 = a; bus1.din1 = b;
    bus1.first = f; bus1.last = l; reset = r;
    if (!r && c && bus1.out_valid === 1'b1) consumed++;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      acc_m = 0;
    end else if (c) begin
      ce_count++;
      if (v) accept(a, b, f, l);
    end
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [16:0] a, input logic [16:0] b, input bit f, input bit l);
    step(1'b1, 1'b1, a, b, f, l, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 17'd0, 17'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int c0;
    // Reset state.
    step(1'b1, 1'b0, 17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
    check("rst_dout1", 64'($signed(bus1.dout)), 64'sd0);
    check("rst_overflow1", 64'(bus1.overflow), 64'sd0);
    check("rst_dout2", 64'($signed(bus2.dout)), 64'sd0);

    // -3 x 5 with latency check.
    send(17'h1FFFD, 17'd5, 1'b1, 1'b1);
    idle(LAT - 2);
    check("lat_early", 64'(bus1.out_valid), 64'sd0);
    idle(1);
    check("lat_valid", 64'(bus1.out_valid), 64'sd1);
    check("neg15_dout1", 64'($signed(bus1.dout)), -64'sd15);
    check("neg15_ovf1", 64'(bus1.overflow), 64'sd0);
    check("neg15_dout2", 64'($signed(bus2.dout)), -64'sd4);

    // Corner product; the narrow instance clips.
    send(17'h10000, 17'h1FFFF, 1'b1, 1'b1);
    idle(LAT - 1);
    check("corner_dout1", 64'($signed(bus1.dout)), -64'sd8589869056);
    check("corner_ovf1", 64'(bus1.overflow), 64'sd0);
    check("corner_dout2", 64'($signed(bus2.dout)), -64'sd32768);
    check("corner_ovf2", 64'(bus2.overflow), 64'sd1);

    // Product 6 rounds to 2 after >>>2.
    send(17'd2, 17'd3, 1'b1, 1'b1);
    idle(LAT - 1);
    check("round_dout2", 64'($signed(bus2.dout)), 64'sd2);
    check("round_dout1", 64'($signed(bus1.dout)), 64'sd6);

    // Back-to-back with ce toggling.
    idle(1);
    c0 = consumed;
    for (int i = 0; i < 16; i++)
      step(i % 2 == 0, 1'b1, 17'(i * 1000 + 7), 17'(i + 1), 1'b1, 1'b1, 1'b0);
    idle(LAT + 2);
    check("b2b_count", 64'(consumed - c0), 64'sd8);

    // Three-sample group.
    send(17'd2, 17'd3, 1'b1, 1'b0);
    send(17'd4, 17'd5, 1'b0, 1'b0);
    send(17'h1FFFF, 17'd6, 1'b0, 1'b1);
    idle(LAT - 1);
    check("group_valid", 64'(bus1.out_valid), 64'sd1);
`ifdef PYR_MUL_ACC_EN
    check("group_dout", 64'($signed(bus1.dout)), 64'sd20);
`else
    check("group_dout", 64'($signed(bus1.dout)), -64'sd6);
`endif

    // Two corner products summed past the 34-bit range.
    send(17'h10000, 17'h1FFFF, 1'b1, 1'b0);
    send(17'h10000, 17'h1FFFF, 1'b0, 1'b1);
    idle(LAT - 1);
`ifdef PYR_MUL_ACC_EN
    check("sat_dout", 64'($signed(bus1.dout)), -64'sd8589934592);
    check("sat_ovf", 64'(bus1.overflow), 64'sd1);
`else
    check("sat_dout", 64'($signed(bus1.dout)), -64'sd8589869056);
    check("sat_ovf", 64'(bus1.overflow), 64'sd0);
`endif

    // Reset with samples in flight.
    idle(LAT);
    send(17'd1, 17'd2, 1'b1, 1'b0);
    send(17'd3, 17'd4, 1'b0, 1'b0);
    send(17'd5, 17'd6, 1'b0, 1'b1);
    step(1'b1, 1'b0, 17'd0, 17'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < LAT + 1; k++) begin
      idle(1);
      check("rst_flush", 64'(bus1.out_valid), 64'sd0);
    end
    send(17'd1, 17'd7, 1'b0, 1'b1);
    idle(LAT - 1);
    check("acc_after_rst", 64'($signed(bus1.dout)), 64'sd7);

    // First arriving mid-group restarts the sum.
    send(17'd2, 17'd2, 1'b1, 1'b0);
    send(17'd3, 17'd3, 1'b0, 1'b0);
    send(17'd1, 17'd1, 1'b1, 1'b0);
    send(17'd5, 17'd1, 1'b0, 1'b1);
    idle(LAT - 1);
`ifdef PYR_MUL_ACC_EN
    check("restart_dout", 64'($signed(bus1.dout)), 64'sd6);
`else
    check("restart_dout", 64'($signed(bus1.dout)), 64'sd5);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 17'($urandom()), 17'($urandom()),
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'b0);
    idle(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
